// File: rtl/iru_rot_scan_gen_if.sv
// Output beat bus of the rotation scan generator: one destination pixel and its rotated source per beat.
// Valid/ready handshake; the master holds every field while out_valid=1 and out_ready=0.
interface iru_rot_scan_gen_if #(
  parameter int COORD_W = 5
);
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] dst_row;
  logic [COORD_W-1:0] dst_col;
  logic [COORD_W-1:0] src_row;
  logic [COORD_W-1:0] src_col;
  logic               src_in;
  logic               out_last;

  modport master (
    output out_valid, dst_row, dst_col, src_row, src_col, src_in, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, dst_row, dst_col, src_row, src_col, src_in, out_last,
    output out_ready
  );
endinterface

// File: rtl/iru_rot_scan_gen.sv
// Raster-sweeps an IMG_DIM x IMG_DIM tile and emits rotated source coordinates; 2-stage pipeline.
// A coordinate issued in cycle N is presented in cycle N+2; the whole pipeline freezes while out_valid & !out_ready.
module iru_rot_scan_gen #(
  parameter int IMG_DIM   = 20,
  parameter int COORD_W   = 5,
  parameter int TRIG_W    = 9,
  parameter int FRAC_BITS = 7,
  parameter int CENTERED  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [TRIG_W-1:0] cos_d,
  input  logic signed [TRIG_W-1:0] sin_d,
  output logic                     busy,
  output logic                     done,
  iru_rot_scan_gen_if.master       beat
);

  localparam int PW = COORD_W + TRIG_W + 2;
  localparam int XW = COORD_W + 1;
  localparam logic [COORD_W-1:0]   LAST  = COORD_W'(IMG_DIM - 1);
  localparam logic signed [XW-1:0] CTR   = (CENTERED != 0) ? XW'(IMG_DIM / 2) : '0;
  localparam logic signed [PW-1:0] CTR_P = (CENTERED != 0) ? PW'(IMG_DIM / 2) : '0;
  localparam logic signed [PW-1:0] DIM_P = PW'(IMG_DIM);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [COORD_W-1:0]       x, y;
  logic signed [TRIG_W-1:0] cos_q, sin_q;
  logic                     advance, issue, at_end, accept_last;

  logic signed [XW-1:0]     xs, ys;
  logic signed [PW-1:0]     xe, ye, ce, se;

  logic                     s1_vld, s1_last;
  logic [COORD_W-1:0]       s1_row, s1_col;
  logic signed [PW-1:0]     p_xc, p_ys, p_xs, p_yc;

  logic signed [PW-1:0]     sx, sy;
  logic                     in_rng;

  assign advance     = !beat.out_valid || beat.out_ready;
  assign at_end      = (x == LAST) && (y == LAST);
  assign accept_last = beat.out_valid && beat.out_ready && beat.out_last;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SCAN;
      SCAN: begin
        if (advance) begin
          issue = 1'b1;
          if (at_end) state_nxt = DRAIN;
        end
      end
      DRAIN: if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && accept_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      cos_q <= '0;
      sin_q <= '0;
    end else if ((state == IDLE) && start) begin
      x     <= '0;
      y     <= '0;
      cos_q <= cos_d;
      sin_q <= sin_d;
    end else if (issue && !at_end) begin
      if (x == LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Offset to the rotation centre, then sign-extend everything to the product width.
  always_comb begin
    xs = $signed({1'b0, x}) - CTR;
    ys = $signed({1'b0, y}) - CTR;
    xe = {{(PW-XW){xs[XW-1]}}, xs};
    ye = {{(PW-XW){ys[XW-1]}}, ys};
    ce = {{(PW-TRIG_W){cos_q[TRIG_W-1]}}, cos_q};
    se = {{(PW-TRIG_W){sin_q[TRIG_W-1]}}, sin_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_row  <= '0;
      s1_col  <= '0;
      p_xc    <= '0;
      p_ys    <= '0;
      p_xs    <= '0;
      p_yc    <= '0;
    end else if (advance) begin
      s1_vld  <= issue;
      s1_last <= issue && at_end;
      s1_row  <= y;
      s1_col  <= x;
      p_xc    <= xe * ce;
      p_ys    <= ye * se;
      p_xs    <= xe * se;
      p_yc    <= ye * ce;
    end
  end

  // Arithmetic shift floors toward -inf, so slightly negative sums land outside the tile.
  always_comb begin
    sx     = ((p_xc - p_ys) >>> FRAC_BITS) + CTR_P;
    sy     = ((p_xs + p_yc) >>> FRAC_BITS) + CTR_P;
    in_rng = !sx[PW-1] && (sx < DIM_P) && !sy[PW-1] && (sy < DIM_P);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat.out_valid <= 1'b0;
      beat.out_last  <= 1'b0;
      beat.dst_row   <= '0;
      beat.dst_col   <= '0;
      beat.src_row   <= '0;
      beat.src_col   <= '0;
      beat.src_in    <= 1'b0;
    end else if (advance) begin
      beat.out_valid <= s1_vld;
      beat.out_last  <= s1_vld && s1_last;
      beat.dst_row   <= s1_row;
      beat.dst_col   <= s1_col;
      beat.src_in    <= in_rng;
      beat.src_row   <= in_rng ? sy[COORD_W-1:0] : '0;
      beat.src_col   <= in_rng ? sx[COORD_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_iru_rot_scan_gen.sv
// Scoreboard bench: each sweep pushes its 400 expected beats, monitors pop and compare on every accepted beat.
module tb_iru_rot_scan_gen;
  localparam int D  = 20;
  localparam int CW = 5;
  localparam int TW = 9;

  typedef logic [21:0] beat_t;  // {last, in, src_row, src_col, dst_row, dst_col}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start0, start1, rdy;
  logic signed [TW-1:0] cos_d, sin_d;
  logic busy0, done0, busy1, done1;

  iru_rot_scan_gen_if #(.COORD_W(CW)) if0 ();
  iru_rot_scan_gen_if #(.COORD_W(CW)) if1 ();
  assign if0.out_ready = rdy;
  assign if1.out_ready = rdy;

  iru_rot_scan_gen #(.IMG_DIM(D), .COORD_W(CW), .TRIG_W(TW), .FRAC_BITS(7), .CENTERED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cos_d(cos_d), .sin_d(sin_d),
    .busy(busy0), .done(done0), .beat(if0));
  iru_rot_scan_gen #(.IMG_DIM(D), .COORD_W(CW), .TRIG_W(TW), .FRAC_BITS(7), .CENTERED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cos_d(cos_d), .sin_d(sin_d),
    .busy(busy1), .done(done1), .beat(if1));

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  int    act = 0;
  int    acc_cnt = 0;
  int    done_cnt = 0;
  bit    last_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int fl7(input int v);
    if (v >= 0) return v / 128;
    return -((-v + 127) / 128);
  endfunction

  function automatic beat_t model(input int x, input int y, input int c, input int s, input int cen);
    int cc, xp, yp, sx, sy;
    bit in, last;
    logic [4:0] r, q;
    cc   = cen ? D / 2 : 0;
    xp   = x - cc;
    yp   = y - cc;
    sx   = fl7(xp * c - yp * s) + cc;
    sy   = fl7(xp * s + yp * c) + cc;
    in   = (sx >= 0) && (sx < D) && (sy >= 0) && (sy < D);
    last = (x == D - 1) && (y == D - 1);
    r    = in ? 5'(sy) : 5'd0;
    q    = in ? 5'(sx) : 5'd0;
    return {last, in, r, q, 5'(y), 5'(x)};
  endfunction

  function automatic beat_t cur(input int u);
    if (u != 0) return {if1.out_last, if1.src_in, if1.src_row, if1.src_col, if1.dst_row, if1.dst_col};
    return {if0.out_last, if0.src_in, if0.src_row, if0.src_col, if0.dst_row, if0.dst_col};
  endfunction
  function automatic logic vld(input int u); return (u != 0) ? if1.out_valid : if0.out_valid; endfunction
  function automatic logic bz(input int u);  return (u != 0) ? busy1 : busy0; endfunction
  function automatic logic dn(input int u);  return (u != 0) ? done1 : done0; endfunction

  task automatic mon(input int u);
    beat_t b;
    if (!rst_n || act != u) return;
    b = cur(u);
    if (dn(u)) done_cnt++;
    if (last_prev) chk("done_after_last", {31'd0, dn(u)}, 32'd1);
    last_prev = vld(u) && rdy && b[21];
    if (vld(u) && rdy) begin
      if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
      else chk($sformatf("beat%0d", acc_cnt), {10'd0, b}, {10'd0, exp_q.pop_front()});
      acc_cnt++;
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic sweep(input int u, input int c, input int s,
                       input int stall_at, input int junk_at, input int rst_at);
    int    lat;
    bit    stalled, junked;
    beat_t snap;
    stalled = 0; junked = 0;
    act = u; acc_cnt = 0; done_cnt = 0; last_prev = 0;
    for (int y = 0; y < D; y++)
      for (int x = 0; x < D; x++)
        exp_q.push_back(model(x, y, c, s, u));
    chk("idle_before_start", {31'd0, bz(u)}, 32'd0);
    cos_d = TW'(c); sin_d = TW'(s);
    if (u != 0) start1 = 1'b1; else start0 = 1'b1;
    lat = 0;
    // Coefficients are scrambled right after acceptance: the DUT must use its latched copy.
    do begin
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0; cos_d = '0; sin_d = '0;
      lat++;
      if (lat == 1) chk("busy_after_start", {31'd0, bz(u)}, 32'd1);
    end while (!vld(u) && lat < 20);
    chk("first_beat_latency", lat, 32'd3);
    for (int cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
      if (rst_at >= 0 && acc_cnt == rst_at) begin
        rst_n = 1'b0; #1;
        chk("rst_valid", {31'd0, vld(u)}, 32'd0);
        chk("rst_busy", {31'd0, bz(u)}, 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          chk("rst_no_done", {31'd0, dn(u)}, 32'd0);
        end
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_idle", {29'd0, bz(u), dn(u), vld(u)}, 32'd0);
        return;
      end
      if (!stalled && acc_cnt == stall_at && vld(u)) begin
        stalled = 1; rdy = 1'b0; snap = cur(u);
        repeat (3) begin
          @(posedge clk); #1;
          chk("stall_hold", {10'd0, cur(u)}, {10'd0, snap});
          chk("stall_valid", {31'd0, vld(u)}, 32'd1);
        end
        chk("stall_no_accept", acc_cnt, stall_at);
        rdy = 1'b1;
      end
      if (!junked && acc_cnt == junk_at) begin
        junked = 1; cos_d = TW'(-c); sin_d = TW'(s + 5);
        if (u != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk("busy_ignore_start", {31'd0, bz(u)}, 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("done_pulses", done_cnt, 32'd1);
    chk("beat_count", acc_cnt, D * D);
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; rdy = 1'b1; cos_d = '0; sin_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state0", {9'd0, busy0, done0, if0.out_valid, cur(0)}, 32'd0);
    chk("rst_state1", {9'd0, busy1, done1, if1.out_valid, cur(1)}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sweep(0,  128,   0, -1, -1,  -1);  // identity
    sweep(0,    0, 128, -1, -1,  -1);  // 90 degrees
    sweep(1, -128,   0, -1, -1,  -1);  // 180 degrees about the centre
    sweep(0,  111,  64, 10, 50,  -1);  // 30 degrees, stall and ignored start
    sweep(0,  128,   0, -1, -1, 150);  // aborted by reset
    sweep(0,  111,  64, -1, -1,  -1);  // full sweep after reset
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/iru_rot_scan_gen.md
Name: iru_rot_scan_gen

Overview:
Sequential, parametrised successor to the image-rotation-unit coordinate computation. On a start pulse it sweeps every destination pixel of an IMG_DIM x IMG_DIM tile in raster order. For each pixel it produces the rotated source coordinate and an in-bounds flag through a 2-stage pipeline with valid/ready backpressure. It sits between the RNN angle decode (cos/sin LUTs) and the IRU pixel fetch, and optionally rotates about the tile centre instead of the origin.

Parameters:
IMG_DIM, 20, tile edge length in pixels (>=2)
COORD_W, 5, coordinate width; must satisfy 2**COORD_W >= IMG_DIM
TRIG_W, 9, signed width of cos/sin coefficients
FRAC_BITS, 7, fractional bits of cos/sin (Q-format; 1.0 = 2**FRAC_BITS)
CENTERED, 0, 0 = rotate about (0,0); 1 = rotate about C = IMG_DIM/2 (integer divide)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only when busy=0
cos_d  input  TRIG_W  signed cosine coefficient, latched on accepted start
sin_d  input  TRIG_W  signed sine coefficient, latched on accepted start
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse after the last beat is accepted
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat when out_valid & out_ready
dst_row  output  COORD_W  destination row (y) of beat
dst_col  output  COORD_W  destination column (x) of beat
src_row  output  COORD_W  rotated source row; 0 when src_in=0
src_col  output  COORD_W  rotated source column; 0 when src_in=0
src_in  output  1  source coordinate lies inside the tile
out_last  output  1  beat is dst (IMG_DIM-1, IMG_DIM-1)

Behaviour:
- Reset (async, rst_n=0): busy, done, out_valid, out_last, src_in = 0; all coordinate outputs = 0; counters, pipeline and latched coefficients cleared; FSM -> IDLE. Reset mid-sweep aborts it with no done pulse.
- FSM IDLE: on start=1, latch cos_d/sin_d, clear x=y=0, go to SCAN; busy=1 next cycle.
- FSM SCAN: issue (x,y) into stage 1 whenever the pipeline advances. x increments first; on x=IMG_DIM-1, x wraps to 0 and y increments. After issuing (IMG_DIM-1, IMG_DIM-1), stop issuing and go to DRAIN.
- FSM DRAIN: wait until the last beat is accepted (out_valid & out_ready & out_last), then pulse done=1 for one cycle, set busy=0, go to IDLE.
- start while busy: ignored; latched coefficients are not changed.
- Pipeline advance: advance = !out_valid | out_ready. On a stall, every stage and every output holds exactly; no beat is lost or duplicated.
- Stage 1 (register): signed products x'*cos, y'*sin, x'*sin, y'*cos, where x'=x-C and y'=y-C if CENTERED, else x'=x and y'=y. Internal signed width is COORD_W+TRIG_W+2.
- Stage 2 (register to outputs):
  - sx = ((x'*cos - y'*sin) >>> FRAC_BITS) + (CENTERED ? C : 0)
  - sy = ((x'*sin + y'*cos) >>> FRAC_BITS) + (CENTERED ? C : 0)
  - The shift is arithmetic, so it floors toward -inf.
  - src_in = (0 <= sx < IMG_DIM) & (0 <= sy < IMG_DIM). When src_in=1, src_col=sx[COORD_W-1:0] and src_row=sy[COORD_W-1:0]; otherwise both are 0.
- Latency: a coordinate issued in cycle N is presented in cycle N+2 when there are no stalls. With out_ready held at 1, exactly IMG_DIM*IMG_DIM beats appear on consecutive cycles, and the first beat appears 3 cycles after accepted start.
- out_last is asserted only on the final beat and is qualified by out_valid.
- dst_row/dst_col travel through the pipeline alongside the products, so they always match the source fields of the same beat.
- Back-to-back sweeps: start may be accepted in the cycle after done.

Test Plan:
1. Identity: cos=128, sin=0, CENTERED=0, ready=1 -> 400 beats. Every beat has src=dst and src_in=1; out_last only on beat 399; done 1 cycle after it; first beat 3 cycles after start.
2. 90 deg: cos=0, sin=128 -> dst(col3,row5) gives sx=-5, so src_in=0 and src=(0,0). dst(col0,row4) gives src_col=0? No: sx=-4, src_in=0. dst(col4,row0) gives src_col=0, src_row=4, src_in=1.
3. 180 deg centred: CENTERED=1, cos=-128, sin=0 -> dst(col3,row5) gives src(col17,row15), src_in=1. dst(col0,row0) gives sx=20, so src_in=0.
4. Floor/rounding at 30 deg: cos=111, sin=64 -> dst(col1,row0) gives src(0,0), src_in=1. dst(col0,row1) gives sx=-64>>>7=-1, so src_in=0.
5. Backpressure: hold out_ready=0 for 3 cycles while beat 10 is valid -> all outputs stable across the stall. Total beats stay 400, in raster order, with no gaps or duplicates; done still fires once.
6. Control: start pulsed while busy with different cos/sin -> ignored, results unchanged. rst_n low at beat 150 -> out_valid=0 and busy=0 immediately, no done pulse; a new start afterwards runs a full 400-beat sweep.
